// File: rtl/uart_serial_pair.sv
// 8N1 UART transmitter and receiver sharing one clock and reset, fixed CLKS_PER_BIT timing.
// Optional UART_RX_SYNC_EN: two-flop synchronizer on i_Rx_Serial instead of a single sample flop.
module uart_serial_pair #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_Clock,
    input  logic       resetn,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state_reg, tx_state_next;
    logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
    logic [2:0]      tx_idx_reg, tx_idx_next;
    logic [7:0]      tx_byte_reg, tx_byte_next;
    logic            tx_serial_reg, tx_serial_next;
    logic            tx_active_reg, tx_active_next;

    always_ff @(posedge i_Clock or negedge resetn) begin
        if (!resetn) begin
            tx_state_reg  <= ST_IDLE;
            tx_cnt_reg    <= '0;
            tx_idx_reg    <= '0;
            tx_byte_reg   <= '0;
            tx_serial_reg <= 1'b1;
            tx_active_reg <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_cnt_reg    <= tx_cnt_next;
            tx_idx_reg    <= tx_idx_next;
            tx_byte_reg   <= tx_byte_next;
            tx_serial_reg <= tx_serial_next;
            tx_active_reg <= tx_active_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg + CNT_ONE;
        tx_idx_next   = tx_idx_reg;
        tx_byte_next  = tx_byte_reg;
        case (tx_state_reg)
            ST_IDLE: begin
                tx_cnt_next = '0;
                tx_idx_next = '0;
                if (i_Tx_DV) begin
                    tx_byte_next  = i_Tx_Byte;
                    tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_idx_next   = '0;
                    tx_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_idx_reg == 3'd7) tx_state_next = ST_STOP;
                    else                    tx_idx_next   = tx_idx_reg + 3'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = ST_IDLE;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase

        // Line and busy flag are registered from the next state so the pin never glitches.
        tx_active_next = (tx_state_next != ST_IDLE);
        case (tx_state_next)
            ST_START: tx_serial_next = 1'b0;
            ST_DATA:  tx_serial_next = tx_byte_next[tx_idx_next];
            default:  tx_serial_next = 1'b1;
        endcase
    end

    assign o_Tx_Active = tx_active_reg;
    assign o_Tx_Serial = tx_serial_reg;

    // ---------------- receiver ----------------
    logic rx_s;
`ifdef UART_RX_SYNC_EN
    logic rx_meta_reg, rx_sync_reg;
    always_ff @(posedge i_Clock or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_Rx_Serial;
            rx_sync_reg <= rx_meta_reg;
        end
    end
    assign rx_s = rx_sync_reg;
`else
    logic rx_sample_reg;
    always_ff @(posedge i_Clock or negedge resetn) begin
        if (!resetn) rx_sample_reg <= 1'b1;
        else         rx_sample_reg <= i_Rx_Serial;
    end
    assign rx_s = rx_sample_reg;
`endif

    state_t          rx_state_reg, rx_state_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [2:0]      rx_idx_reg, rx_idx_next;
    logic [7:0]      rx_shift_reg, rx_shift_next;
    logic [7:0]      rx_byte_reg, rx_byte_next;
    logic            rx_dv_reg, rx_dv_next;

    always_ff @(posedge i_Clock or negedge resetn) begin
        if (!resetn) begin
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte_reg  <= '0;
            rx_dv_reg    <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_idx_reg   <= rx_idx_next;
            rx_shift_reg <= rx_shift_next;
            rx_byte_reg  <= rx_byte_next;
            rx_dv_reg    <= rx_dv_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + CNT_ONE;
        rx_idx_next   = rx_idx_reg;
        rx_shift_next = rx_shift_reg;
        rx_byte_next  = rx_byte_reg;
        rx_dv_next    = rx_dv_reg;
        case (rx_state_reg)
            ST_IDLE: begin
                rx_cnt_next = '0;
                rx_idx_next = '0;
                if (!rx_s) rx_state_next = ST_START;
            end
            ST_START: begin
                // DV is a polled level: it only drops once a real start bit is confirmed.
                if (rx_cnt_reg == CNT_MID) begin
                    rx_cnt_next = '0;
                    if (!rx_s) begin
                        rx_dv_next    = 1'b0;
                        rx_idx_next   = '0;
                        rx_state_next = ST_DATA;
                    end else begin
                        rx_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next               = '0;
                    rx_shift_next[rx_idx_reg] = rx_s;
                    if (rx_idx_reg == 3'd7) rx_state_next = ST_STOP;
                    else                    rx_idx_next   = rx_idx_reg + 3'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = ST_IDLE;
                    if (rx_s) begin
                        rx_byte_next = rx_shift_reg;
                        rx_dv_next   = 1'b1;
                    end
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    assign o_Rx_DV   = rx_dv_reg;
    assign o_Rx_Byte = rx_byte_reg;

endmodule

// File: tb/tb_uart_serial_pair.sv
// Randomized scoreboard bench for uart_serial_pair at 4 clocks per bit: TX frames and RX bytes
// are queued at stimulus time and checked by independent monitors.
module tb_uart_serial_pair;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx_active, tx_serial, rx_dv, rx_line;
    logic [7:0] rx_byte;

    assign rx_line = loop_en ? tx_serial : rx_drv;

    uart_serial_pair #(.CLKS_PER_BIT(C)) dut (
        .i_Clock    (clk),
        .resetn     (resetn),
        .i_Tx_DV    (tx_dv),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Active(tx_active),
        .o_Tx_Serial(tx_serial),
        .i_Rx_Serial(rx_line),
        .o_Rx_DV    (rx_dv),
        .o_Rx_Byte  (rx_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         rx_t0_q[$];
    logic       exp_dv = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX monitor: records each active period and compares it against the queued byte.
    initial begin : tx_monitor
        bit         cap;
        int         n;
        logic       smp[0:63];
        logic [9:0] exp_f, obs;
        bit         cons;
        logic [7:0] eb;
        cap = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                cap = 0;
                n = 0;
            end else if (tx_active) begin
                cap = 1;
                if (n < 64) smp[n] = tx_serial;
                n++;
            end else begin
                if (cap) begin
                    cap = 0;
                    check("tx_active_len", n == 10 * C, n, 10 * C);
                    if (tx_q.size() == 0) begin
                        check("tx_unexpected_frame", 1'b0, n, 0);
                    end else begin
                        eb = tx_q.pop_front();
                        exp_f = {1'b1, eb, 1'b0};
                        obs = '0;
                        cons = 1;
                        for (int s = 0; s < 10; s++) begin
                            obs[s] = smp[s * C];
                            for (int k = 1; k < C; k++)
                                if (smp[s * C + k] !== smp[s * C]) cons = 0;
                        end
                        check("tx_frame", cons && (obs == exp_f), obs, exp_f);
                    end
                    n = 0;
                end
                check("tx_idle_high", tx_serial == 1'b1, tx_serial, 1);
            end
        end
    end

    // RX monitor: each DV rising edge consumes one expected byte; byte must hold while DV is high.
    initial begin : rx_monitor
        logic       prev_dv;
        logic [7:0] held, eb;
        int         t0, lat;
        prev_dv = 0;
        held = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_dv = 0;
            end else begin
                if (rx_dv && !prev_dv) begin
                    if (rx_q.size() == 0) begin
                        check("rx_unexpected_dv", 1'b0, rx_byte, 0);
                    end else begin
                        eb = rx_q.pop_front();
                        t0 = rx_t0_q.pop_front();
                        check("rx_byte", rx_byte == eb, rx_byte, eb);
                        if (t0 >= 0) begin
                            lat = cyc - t0;
                            check("rx_dv_latency", lat >= 9 * C + C / 2 && lat <= 10 * C + 2, lat, 10 * C);
                        end
                    end
                    held = rx_byte;
                end else if (rx_dv && prev_dv) begin
                    check("rx_byte_stable", rx_byte == held, rx_byte, held);
                end
                prev_dv = rx_dv;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_serial"}, tx_serial == 1'b1, tx_serial, 1);
        check({tag, "_tx_active"}, tx_active == 1'b0, tx_active, 0);
        check({tag, "_rx_dv"},     rx_dv == 1'b0,     rx_dv, 0);
        check({tag, "_rx_byte"},   rx_byte == 8'h00,  rx_byte, 0);
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while (tx_active && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_wait_idle", t < 200, t, 200);
    endtask

    task automatic tx_send(input logic [7:0] b, input bit push);
        @(negedge clk);
        wait_tx_idle();
        tx_dv = 1'b1;
        tx_byte = b;
        if (push) tx_q.push_back(b);
        @(negedge clk);
        tx_dv = 1'b0;
        tx_byte = 8'($urandom);
    endtask

    task automatic tx_ignored(input logic [7:0] b);
        check("tx_busy_before_extra_dv", tx_active == 1'b1, tx_active, 1);
        tx_dv = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    // Called at a negedge; drives one 8N1 frame then `gap` idle cycles.
    task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        if (stop_ok) begin
            rx_q.push_back(b);
            rx_t0_q.push_back(cyc);
        end
        for (int s = 0; s < 10; s++) begin
            rx_drv = f[s];
            if (s == 0) begin
                @(negedge clk);
                check("rx_dv_hold", rx_dv == exp_dv, rx_dv, exp_dv);
                repeat (C - 1) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        rx_drv = 1'b1;
        exp_dv = stop_ok;
        if (stop_ok) last_good = b;
        if (gap > 0) begin
            repeat (gap) @(negedge clk);
            check("rx_dv_after_frame", rx_dv == exp_dv, rx_dv, exp_dv);
            check("rx_byte_after_frame", rx_byte == last_good, rx_byte, last_good);
        end
    endtask

    task automatic rx_glitch();
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * C + 2) @(negedge clk);
        check("rx_glitch_dv", rx_dv == exp_dv, rx_dv, exp_dv);
        check("rx_glitch_byte", rx_byte == last_good, rx_byte, last_good);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] b;
        bit ok;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // TX: A5 with an ignored 3C request in mid-frame
        tx_send(8'hA5, 1);
        repeat (10) @(negedge clk);
        tx_ignored(8'h3C);
        wait_tx_idle();
        repeat (6) @(negedge clk);

        // RX directed cases
        rx_frame(8'h5A, 1, 3);
        rx_glitch();
        rx_frame(8'hFF, 1, 3);
        rx_frame(8'h81, 0, 2 * C + 2);
        rx_frame(8'h42, 1, 3);

        // Continuous RX stream with no idle gap
        rx_frame(8'($urandom), 1, 0);
        rx_frame(8'($urandom), 1, 0);
        rx_frame(8'($urandom), 1, 3);

        // Randomized RX frames, some with framing errors
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            rx_frame(b, ok, ok ? 2 + $urandom_range(0, 3) : 2 * C + $urandom_range(2, 5));
        end

        // Randomized TX frames with stray requests while busy
        for (int i = 0; i < 8; i++) begin
            tx_send(8'($urandom), 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 20)) @(negedge clk);
                tx_ignored(8'($urandom));
            end
        end
        wait_tx_idle();
        repeat (4) @(negedge clk);

        // Loopback: back-to-back 00 then FF
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        rx_q.push_back(8'h00); rx_t0_q.push_back(-1);
        rx_q.push_back(8'hFF); rx_t0_q.push_back(-1);
        tx_send(8'h00, 1);
        tx_send(8'hFF, 1);
        @(negedge clk);
        wait_tx_idle();
        repeat (12) @(negedge clk);
        check("loop_rx_queue_drained", rx_q.size() == 0, rx_q.size(), 0);
        check("loop_rx_byte_ff", rx_byte == 8'hFF, rx_byte, 8'hFF);
        check("loop_rx_dv", rx_dv == 1'b1, rx_dv, 1);

        // Loopback again, reset asserted in the middle of the second frame
        b = 8'($urandom);
        rx_q.push_back(b); rx_t0_q.push_back(-1);
        tx_send(b, 1);
        tx_send(8'($urandom), 0);
        repeat (15) @(negedge clk);
        check("tx_active_before_reset", tx_active == 1'b1, tx_active, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        resetn = 1'b1;
        loop_en = 1'b0;
        repeat (6) @(negedge clk);
        check("final_tx_queue_empty", tx_q.size() == 0, tx_q.size(), 0);
        check("final_rx_queue_empty", rx_q.size() == 0, rx_q.size(), 0);
        check("post_reset_rx_dv", rx_dv == 1'b0, rx_dv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_serial_pair.md
Name: uart_serial_pair

Overview:
- 8N1 UART transmitter plus receiver in one block, sharing one clock and one reset.
- Sits in the SoC IO page. The CPU writes a byte to start a transmission. The CPU polls the transmit-busy and receive-data-valid status bits, then reads the received byte.
- Fixed baud timing via a clocks-per-bit parameter. No parity, one stop bit, LSB first.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per serial bit (27 MHz / 115200 baud); legal range 4..65535.

Ports:
- i_Clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_Tx_DV  in  1  transmit request; one-cycle strobe carrying i_Tx_Byte.
- i_Tx_Byte  in  8  byte to transmit, sampled when i_Tx_DV=1 and idle.
- o_Tx_Active  out  1  high while a frame is being sent.
- o_Tx_Serial  out  1  serial TX line, idle high.
- i_Rx_Serial  in  1  serial RX line, asynchronous, idle high.
- o_Rx_DV  out  1  received-byte-valid status (level, see below).
- o_Rx_Byte  out  8  last correctly framed received byte.

Behaviour:
- Reset (async, resetn=0):
  - Both FSMs go to IDLE; counters clear.
  - o_Tx_Serial=1, o_Tx_Active=0, o_Rx_DV=0, o_Rx_Byte=0.
  - Reset mid-frame aborts immediately; the TX line returns high.
- Bit timer: a counter from 0 to CLKS_PER_BIT-1, one per FSM, sized $clog2(CLKS_PER_BIT)+1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: line=1, Active=0. On i_Tx_DV=1, latch i_Tx_Byte and go to START. Next cycle: Active=1, line=0.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line=byte[index] for CLKS_PER_BIT cycles each, index 0..7 (LSB first), then STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then IDLE with Active=0 in the same edge.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back: a DV in the first IDLE cycle starts the next frame.
  - i_Tx_DV while Active=1 is ignored; the byte is not queued and the latched byte is unaffected.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for sampled rx=0.
  - START: count to (CLKS_PER_BIT-1)/2, the mid start bit.
    - If rx still 0: clear o_Rx_DV, reset the timer, go to DATA with index 0.
    - Else: glitch, return to IDLE and leave DV unchanged.
  - DATA: wait CLKS_PER_BIT cycles, sample rx into shift[index], LSB first. After index 7 go to STOP.
  - STOP: wait CLKS_PER_BIT cycles (mid stop bit) and sample.
    - rx=1: o_Rx_Byte<=shift, o_Rx_DV<=1.
    - rx=0 (framing error): discard; o_Rx_Byte and o_Rx_DV unchanged.
    - Either way, return to IDLE.
- o_Rx_DV is a level, so a polling CPU cannot miss it:
  - Set at the good stop sample.
  - Held until the next valid start bit is confirmed at mid start.
  - o_Rx_Byte holds stable while DV=1. A new byte overwrites it (no overrun flag).
- Continuous RX stream: a start edge immediately after the mid stop sample is accepted.
- TX and RX are fully independent; loopback (tx wired to rx) works.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: i_Rx_Serial passes through a two-flop synchronizer, both flops reset to 1, before the RX FSM. This adds 2 cycles of latency to all RX sampling points.
- Undefined: a single registered sample of i_Rx_Serial, reset to 1, feeds the FSM (1 cycle latency).
- TX is unaffected either way.

Test Plan:
- CLKS_PER_BIT=4, reset released, pulse i_Tx_DV with i_Tx_Byte=8'hA5:
  - o_Tx_Active=1 for 40 cycles.
  - o_Tx_Serial per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - Then idle high, Active=0.
- Pulse i_Tx_DV with 8'h3C mid-frame of 8'hA5: the second request is ignored; the waveform matches A5 exactly, then the line stays idle.
- Drive i_Rx_Serial with 8N1 frame 8'h5A at 4 clocks/bit:
  - o_Rx_DV rises after the mid stop sample, with o_Rx_Byte=8'h5A.
  - DV stays high until the next frame's start is confirmed.
- Start-bit glitch (rx low for 1 cycle) -> no DV change; FSM back to IDLE. A following frame 8'hFF is received correctly.
- Frame 8'h81 with stop bit forced 0 -> o_Rx_DV stays 0 and o_Rx_Byte keeps its previous value. Next good frame 8'h42 -> DV=1, byte=8'h42.
- Loopback tx->rx, send 8'h00 then 8'hFF back-to-back -> o_Rx_Byte=8'h00 then 8'hFF.
  - Assert resetn=0 mid second frame -> all outputs return to reset values asynchronously.
